// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector: assembles LSB-first serial frames into WIDTH-bit
// words and presents each one on a registered valid/ready output.
`timescale 1ns/1ps

module serial_word_collector #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             complete, restart;
  logic [WIDTH-1:0] shifted;

  // Incoming bits enter at the MSB, so the first bit lands in bit 0 after WIDTH shifts.
  assign shifted = {din, sr_q[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      sr_q        <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sr_q        <= sr_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sr_d     = sr_q;
    complete = 1'b0;
    restart  = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            sr_d    = shifted;
            count_d = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sr_d = shifted;
          if (frame_start) begin
            // A restart wins over completion, even on the last bit position.
            restart = 1'b1;
            count_d = CW'(1);
          end else begin
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
              complete = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    word_d      = word_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = restart;
    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule
